// File: rtl/p_transpose_stream_if.sv
// p_transpose_stream_if: row-in / column-out stream bundle.
// slave = transpose block side; master = producer/consumer side.
//   in_valid_i/in_ready_o/in_data_i     : N-element row beats in
//   out_valid_o/out_ready_i/out_data_o  : N-element column beats out
//   out_last_o                          : final column beat of a block
interface p_transpose_stream_if #(
  parameter int N  = 8,
  parameter int EW = 8
);
  localparam int BW = N * EW;

  logic          in_valid_i;
  logic          in_ready_o;
  logic [BW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [BW-1:0] out_data_o;
  logic          out_last_o;

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o,
    output out_last_o
  );

  modport master (
    output in_valid_i,
    output in_data_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o,
    input  out_last_o
  );
endinterface

// File: rtl/p_transpose_stream.sv
// p_transpose_stream: streaming N x N element transpose, ping-pong banks.
// Rows in (row 0 first), columns out; element 0 sits at the beat MSB.
//   clk_i, rst_i : clock, async active-high reset
//   bus (slave)  : row stream in, column stream out with out_last_o
// Macro P_TRANSPOSE_OREG_EN adds a 2-entry registered skid stage on the
// output so out_ready_i has no combinational path to any output.
module p_transpose_stream #(
  parameter int N  = 8,
  parameter int EW = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  p_transpose_stream_if.slave bus
);
  localparam int BW = N * EW;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [BW-1:0] mem_q [2][N];
  logic [BW-1:0] mem_d [2][N];

  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic [CW-1:0] wr_row_q, wr_row_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] rd_col_q, rd_col_d;

  logic          wr_fire;
  logic          rd_fire;
  logic          bank_valid;
  logic          bank_ready;
  logic          bank_last;
  logic [BW-1:0] col_data;

  // Writing needs !full and reading needs full, so one bank is never
  // both written and read in a cycle.
  assign bus.in_ready_o = !full_q[wr_bank_q];
  assign wr_fire    = bus.in_valid_i && !full_q[wr_bank_q];
  assign bank_valid = full_q[rd_bank_q];
  assign bank_last  = (rd_col_q == LAST);
  assign rd_fire    = bank_valid && bank_ready;

  // Column rd_col of the read bank: element r comes from row r.
  always_comb begin : gather
    col_data = '0;
    for (int r = 0; r < N; r++) begin
      col_data[(N-r)*EW-1 -: EW] =
        EW'(mem_q[rd_bank_q][r] >> ((N - 1 - int'(rd_col_q)) * EW));
    end
  end

  always_comb begin : mem_next
    mem_d = mem_q;
    if (wr_fire) begin
      mem_d[wr_bank_q][wr_row_q] = bus.in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_comb begin : ctl_next
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;
    if (wr_fire) begin
      if (wr_row_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_row_d  = '0;
        wr_bank_d = !wr_bank_q;
      end else begin
        wr_row_d = wr_row_q + CW'(1);
      end
    end
    // Set and clear always target different banks here.
    if (rd_fire) begin
      if (bank_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_col_d  = '0;
        rd_bank_d = !rd_bank_q;
      end else begin
        rd_col_d = rd_col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
      rd_col_q  <= rd_col_d;
    end
  end

`ifdef P_TRANSPOSE_OREG_EN
  // Two-entry skid: entry 0 is the head. Filling only depends on the
  // occupancy, so out_ready_i never reaches the bank side combinationally.
  logic [BW:0] skid_q [2];
  logic [BW:0] skid_d [2];
  logic [1:0]  cnt_q, cnt_d;
  logic        pop;

  assign bank_ready = (cnt_q != 2'd2);
  assign pop        = bus.out_ready_i && (cnt_q != 2'd0);

  always_comb begin : skid_next
    skid_d = skid_q;
    cnt_d  = cnt_q;
    if (pop) begin
      skid_d[0] = skid_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    // After a pop the fill level is 0 or 1, which is the write slot.
    if (rd_fire) begin
      skid_d[cnt_d[0]] = {bank_last, col_data};
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      skid_q[0] <= '0;
      skid_q[1] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      skid_q[0] <= skid_d[0];
      skid_q[1] <= skid_d[1];
    end
  end

  assign bus.out_valid_o = (cnt_q != 2'd0);
  assign bus.out_data_o  = skid_q[0][BW-1:0];
  assign bus.out_last_o  = (cnt_q != 2'd0) && skid_q[0][BW];
`else
  assign bank_ready      = bus.out_ready_i;
  assign bus.out_valid_o = bank_valid;
  assign bus.out_data_o  = col_data;
  assign bus.out_last_o  = bank_valid && bank_last;
`endif
endmodule

// File: tb/tb_p_transpose_stream.sv
// tb_p_transpose_stream: directed bench with scoreboard for the
// streaming transpose (N=8/EW=8 main instance, N=4/EW=16 second).
module tb_p_transpose_stream;
  localparam int N = 8;
`ifdef P_TRANSPOSE_OREG_EN
  localparam int LAT   = 2;
  localparam int DRAIN = 7;
`else
  localparam int LAT   = 1;
  localparam int DRAIN = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  p_transpose_stream_if #(.N(8), .EW(8))  bus ();
  p_transpose_stream_if #(.N(4), .EW(16)) bus4 ();

  p_transpose_stream #(.N(8), .EW(8)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  p_transpose_stream #(.N(4), .EW(16)) u_dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [64:0] exp_q [$];
  logic [63:0] rows_q [$];
  logic [63:0] got_q [$];
  logic        got_l_q [$];
  int cyc = 0;
  int nbeats = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int stalls = 0;
  logic        hold_pend = 1'b0;
  logic [64:0] hold_val = '0;

  task automatic chk(string tag, logic [64:0] obs, logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full 512-bit byte-matrix P permutation: output byte j (MSB first)
  // takes input byte (j mod 8)*8 + j/8.
  function automatic logic [511:0] p_perm(logic [511:0] x);
    logic [511:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) begin
      y[511-8*j -: 8] = x[511-8*((j%8)*8 + j/8) -: 8];
    end
    return y;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [64:0] e;
    logic [64:0] o;
    o = {bus.out_last_o, bus.out_data_o};
    if (!rst && hold_pend) begin
      chk("hold_valid", 65'(bus.out_valid_o), 65'(1));
      chk("hold_beat", o, hold_val);
    end
    hold_pend = !rst && bus.out_valid_o && !bus.out_ready_i;
    hold_val  = o;
    if (!rst && bus.in_valid_i && !bus.in_ready_o) stalls++;
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      chk("sb_nonempty", 65'(exp_q.size() != 0), 65'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", o, e);
      end
      got_q.push_back(bus.out_data_o);
      got_l_q.push_back(bus.out_last_o);
      if (nbeats == 0) first_cyc = cyc;
      last_cyc = cyc;
      nbeats++;
    end
  end

  // Drive rows_q back to back, holding each row until accepted.
  task automatic feed();
    logic [511:0] blk;
    logic [511:0] y;
    int nacc = 0;
    int i = 0;
    int guard = 0;
    int total;
    logic acc;
    blk = '0;
    total = rows_q.size();
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = rows_q[0];
    while (i < total && guard < 2000) begin
      @(negedge clk);
      acc = bus.in_ready_o;
      @(posedge clk);
      #1;
      if (acc) begin
        blk = {blk[447:0], rows_q[i]};
        i++;
        nacc++;
        if (nacc == N) begin
          y = p_perm(blk);
          for (int k = 0; k < N; k++) begin
            exp_q.push_back({k == N - 1, y[511-64*k -: 64]});
          end
          nacc = 0;
        end
        if (i < total) bus.in_data_i = rows_q[i];
      end else begin
        guard++;
      end
    end
    bus.in_valid_i = 1'b0;
    chk("feed_done", 65'(i), 65'(total));
    rows_q.delete();
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain", 65'(exp_q.size()), 65'(0));
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_obs();
    got_q.delete();
    got_l_q.delete();
    nbeats = 0;
  endtask

  task automatic rand_rows(int n);
    for (int i = 0; i < n; i++) rows_q.push_back({$urandom, $urandom});
  endtask

  initial begin
    logic [64:0] hv;
    logic [63:0] d4;
    int nl;
    logic done;

    bus.in_valid_i   = 1'b0;
    bus.in_data_i    = '0;
    bus.out_ready_i  = 1'b1;
    bus4.in_valid_i  = 1'b0;
    bus4.in_data_i   = '0;
    bus4.out_ready_i = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", 65'(bus.out_valid_o), 65'(0));
    chk("rst_out_last", 65'(bus.out_last_o), 65'(0));
    chk("rst_in_ready", 65'(bus.in_ready_o), 65'(1));
    chk("rst4_out_valid", 65'(bus4.out_valid_o), 65'(0));
    chk("rst4_in_ready", 65'(bus4.in_ready_o), 65'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: directed byte-index matrix
    clr_obs();
    for (int r = 0; r < 8; r++) begin
      logic [63:0] row;
      for (int c = 0; c < 8; c++) row[63-8*c -: 8] = {4'(r), 4'(c)};
      rows_q.push_back(row);
    end
    feed();
    chk("t1_lat_now", 65'(bus.out_valid_o), 65'(LAT == 1));
    @(posedge clk);
    #1;
    chk("t1_lat_next", 65'(bus.out_valid_o), 65'(1));
    wait_drain();
    chk("t1_nbeats", 65'(nbeats), 65'(8));
    chk("t1_beat0", 65'(got_q[0]), 65'(64'h0010203040506070));
    chk("t1_beat7", 65'(got_q[7]), 65'(64'h0717273747576777));
    nl = 0;
    for (int k = 0; k < got_l_q.size(); k++) nl += int'(got_l_q[k]);
    chk("t1_last_cnt", 65'(nl), 65'(1));
    chk("t1_last_pos", 65'(got_l_q[7]), 65'(1));

    // Test 2: three back-to-back random blocks, full rate
    clr_obs();
    stalls = 0;
    rand_rows(24);
    feed();
    wait_drain();
    chk("t2_no_stall", 65'(stalls), 65'(0));
    chk("t2_nbeats", 65'(nbeats), 65'(24));
    chk("t2_no_gap", 65'(last_cyc - first_cyc), 65'(23));

    // Test 3: backpressure with both banks full
    clr_obs();
    bus.out_ready_i = 1'b0;
    rand_rows(16);
    feed();
    chk("t3_in_ready_low", 65'(bus.in_ready_o), 65'(0));
    hv = exp_q[0];
    repeat (4) begin
      chk("t3_valid", 65'(bus.out_valid_o), 65'(1));
      chk("t3_beat0", {bus.out_last_o, bus.out_data_o}, hv);
      @(posedge clk);
      #1;
    end
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < DRAIN; i++) begin
      @(posedge clk);
      #1;
      chk("t3_in_ready_ret", 65'(bus.in_ready_o), 65'(i == DRAIN - 1));
    end
    wait_drain();
    chk("t3_nbeats", 65'(nbeats), 65'(16));

    // Test 4: async reset mid-block
    clr_obs();
    bus.out_ready_i = 1'b0;
    rand_rows(14);
    feed();
    chk("t4_pre_valid", 65'(bus.out_valid_o), 65'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("t4_rst_valid", 65'(bus.out_valid_o), 65'(0));
    chk("t4_rst_ready", 65'(bus.in_ready_o), 65'(1));
    chk("t4_rst_last", 65'(bus.out_last_o), 65'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clr_obs();
    bus.out_ready_i = 1'b1;
    rand_rows(8);
    feed();
    wait_drain();
    chk("t4_nbeats", 65'(nbeats), 65'(8));

    // Test 5: N=4, EW=16 instance
    bus4.in_valid_i = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) d4[63-16*c -: 16] = 16'(16 * r + c);
      bus4.in_data_i = d4;
      chk("t5_in_ready", 65'(bus4.in_ready_o), 65'(1));
      @(posedge clk);
      #1;
    end
    bus4.in_valid_i = 1'b0;
    repeat (LAT - 1) begin
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 4; r++) d4[63-16*r -: 16] = 16'(16 * r + k);
      chk("t5_valid", 65'(bus4.out_valid_o), 65'(1));
      chk("t5_beat", {bus4.out_last_o, bus4.out_data_o}, {k == 3, d4});
      @(posedge clk);
      #1;
    end
    chk("t5_idle", 65'(bus4.out_valid_o), 65'(0));

    // Test 6: random downstream stalls
    clr_obs();
    done = 1'b0;
    rand_rows(24);
    fork
      begin
        feed();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready_i = 1'b1;
    wait_drain();
    chk("t6_nbeats", 65'(nbeats), 65'(24));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
